// File: rtl/usb_tx_nrzi.sv
// USB transmit serializer: SYNC, bit-stuffed NRZI packet data drained from a 1-bit FIFO, then EOP.
// The line pair changes only on bit_stb; J/K polarity is selected by LOW_SPEED.
`timescale 1ns/1ps
module usb_tx_nrzi #(
    parameter bit LOW_SPEED = 1'b0,
    parameter int STUFF_LEN = 6
) (
    input  logic clk,
    input  logic rst0_async,
    input  logic rst0_sync,
    input  logic bit_stb,
    input  logic tx_start,
    input  logic fifo_rd_data,
    input  logic fifo_empty,
    output logic fifo_rd_en,
    output logic tx_dp,
    output logic tx_dn,
    output logic tx_oe,
    output logic tx_active,
    output logic tx_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        EOP1 = 3'd3,
        EOP2 = 3'd4,
        EOP3 = 3'd5
    } state_t;

    localparam logic       J_DP      = LOW_SPEED ? 1'b0 : 1'b1;
    localparam logic       J_DN      = ~J_DP;
    localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN);

    state_t     state, state_n;
    logic       line_k, line_k_n;
    logic [2:0] ones_cnt, ones_n;
    logic [2:0] bit_cnt, bit_n;
    logic       dp_n, dn_n, oe_n, active_n, done_n;
    logic       drive_level;

    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            state     <= IDLE;
            line_k    <= 1'b0;
            ones_cnt  <= 3'd0;
            bit_cnt   <= 3'd0;
            tx_dp     <= J_DP;
            tx_dn     <= J_DN;
            tx_oe     <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else if (!rst0_sync) begin
            state     <= IDLE;
            line_k    <= 1'b0;
            ones_cnt  <= 3'd0;
            bit_cnt   <= 3'd0;
            tx_dp     <= J_DP;
            tx_dn     <= J_DN;
            tx_oe     <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            line_k    <= line_k_n;
            ones_cnt  <= ones_n;
            bit_cnt   <= bit_n;
            tx_dp     <= dp_n;
            tx_dn     <= dn_n;
            tx_oe     <= oe_n;
            tx_active <= active_n;
            tx_done   <= done_n;
        end
    end

    // line_k tracks the NRZI level (0 = J); SE0 is written straight onto dp/dn.
    always_comb begin
        state_n     = state;
        line_k_n    = line_k;
        ones_n      = ones_cnt;
        bit_n       = bit_cnt;
        dp_n        = tx_dp;
        dn_n        = tx_dn;
        oe_n        = tx_oe;
        active_n    = tx_active;
        done_n      = 1'b0;
        fifo_rd_en  = 1'b0;
        drive_level = 1'b0;

        case (state)
            IDLE: begin
                if (tx_start && !fifo_empty) begin
                    state_n  = SYNC;
                    active_n = 1'b1;
                    bit_n    = 3'd0;
                    ones_n   = 3'd0;
                    line_k_n = 1'b0;
                end
            end
            SYNC: begin
                if (bit_stb) begin
                    oe_n        = 1'b1;
                    drive_level = 1'b1;
                    bit_n       = bit_cnt + 3'd1;
                    if (bit_cnt != 3'd7) begin
                        line_k_n = ~line_k;
                    end else begin
                        // The trailing SYNC 1 counts toward the stuffing run.
                        ones_n  = 3'd1;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_stb) begin
                    if (ones_cnt == STUFF_MAX) begin
                        line_k_n    = ~line_k;
                        ones_n      = 3'd0;
                        drive_level = 1'b1;
                    end else if (!fifo_empty) begin
                        // A pop during a synchronous clear would lose the bit.
                        fifo_rd_en  = rst0_sync;
                        drive_level = 1'b1;
                        if (fifo_rd_data) begin
                            ones_n = ones_cnt + 3'd1;
                        end else begin
                            line_k_n = ~line_k;
                            ones_n   = 3'd0;
                        end
                    end else begin
                        dp_n    = 1'b0;
                        dn_n    = 1'b0;
                        state_n = EOP1;
                    end
                end
            end
            EOP1: begin
                if (bit_stb) begin
                    dp_n    = 1'b0;
                    dn_n    = 1'b0;
                    state_n = EOP2;
                end
            end
            EOP2: begin
                if (bit_stb) begin
                    line_k_n    = 1'b0;
                    drive_level = 1'b1;
                    state_n     = EOP3;
                end
            end
            EOP3: begin
                if (bit_stb) begin
                    line_k_n    = 1'b0;
                    drive_level = 1'b1;
                    oe_n        = 1'b0;
                    active_n    = 1'b0;
                    done_n      = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (drive_level) begin
            dp_n = line_k_n ? ~J_DP : J_DP;
            dn_n = ~dp_n;
        end
    end

endmodule

// File: tb/tb_usb_tx_nrzi.sv
// Scoreboard bench for usb_tx_nrzi: a reference model queues the expected per-strobe line
// symbols for each packet, and every strobe pops and compares one entry.
`timescale 1ns/1ps
module tb_usb_tx_nrzi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_async, rst0_sync, bit_stb, tx_start;
    logic fifo_rd_data, fifo_empty;
    logic fifo_rd_en, tx_dp, tx_dn, tx_oe, tx_active, tx_done;
    logic ls_rd_en, ls_dp, ls_dn, ls_oe, ls_active, ls_done;

    logic fifo_mem [0:63];
    int   rd_ptr = 0;
    int   wr_ptr = 0;

    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;
    int   pop_cnt = 0;

    logic [4:0] exp_q[$];
    logic [4:0] exp_ls_q[$];
    logic       pkt [0:63];
    int         pkt_len;
    logic [4:0] obs, obs_ls;
    logic       obs_rd, obs_rd_ls;

    usb_tx_nrzi #(.LOW_SPEED(1'b0), .STUFF_LEN(6)) dut (
        .clk(clk), .rst0_async(rst0_async), .rst0_sync(rst0_sync), .bit_stb(bit_stb),
        .tx_start(tx_start), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .tx_dp(tx_dp), .tx_dn(tx_dn), .tx_oe(tx_oe),
        .tx_active(tx_active), .tx_done(tx_done)
    );

    usb_tx_nrzi #(.LOW_SPEED(1'b1), .STUFF_LEN(6)) dut_ls (
        .clk(clk), .rst0_async(rst0_async), .rst0_sync(rst0_sync), .bit_stb(bit_stb),
        .tx_start(tx_start), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(ls_rd_en), .tx_dp(ls_dp), .tx_dn(ls_dn), .tx_oe(ls_oe),
        .tx_active(ls_active), .tx_done(ls_done)
    );

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_rd_data = fifo_mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1 && !fifo_empty) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [1:0] line_sym(input bit ls, input bit k, input bit se0);
        if (se0) return 2'b00;
        return (k ^ ls) ? 2'b01 : 2'b10;
    endfunction

    task automatic push_exp(input bit ls, input logic [4:0] e);
        if (ls) exp_ls_q.push_back(e);
        else    exp_q.push_back(e);
    endtask

    // Expected entry per strobe: {oe, done, pop, dp, dn}.
    task automatic model_packet(input bit ls);
        bit k = 1'b0;
        int ones;
        int idx = 0;
        bit data_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i != 7) k = ~k;
            push_exp(ls, {3'b100, line_sym(ls, k, 1'b0)});
        end
        ones = 1;
        while (!data_done) begin
            if (ones == 6) begin
                k = ~k;
                ones = 0;
                push_exp(ls, {3'b100, line_sym(ls, k, 1'b0)});
            end else if (idx < pkt_len) begin
                if (pkt[idx]) ones++;
                else begin
                    k = ~k;
                    ones = 0;
                end
                idx++;
                push_exp(ls, {3'b101, line_sym(ls, k, 1'b0)});
            end else begin
                data_done = 1'b1;
            end
        end
        push_exp(ls, {3'b100, 2'b00});
        push_exp(ls, {3'b100, 2'b00});
        push_exp(ls, {3'b100, line_sym(ls, 1'b0, 1'b0)});
        push_exp(ls, {3'b010, line_sym(ls, 1'b0, 1'b0)});
    endtask

    task automatic set_pkt(input logic [15:0] bits, input int n);
        for (int i = 0; i < 16; i++) pkt[i] = bits[i];
        pkt_len = n;
    endtask

    task automatic load_fifo();
        for (int i = 0; i < pkt_len; i++) begin
            fifo_mem[wr_ptr[5:0]] = pkt[i];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic start_packet(input bit with_stb);
        @(negedge clk);
        tx_start = 1'b1;
        bit_stb  = with_stb;
        @(negedge clk);
        tx_start = 1'b0;
        bit_stb  = 1'b0;
    endtask

    task automatic step_bit();
        @(negedge clk);
        bit_stb = 1'b1;
        #1;
        obs_rd    = fifo_rd_en;
        obs_rd_ls = ls_rd_en;
        @(negedge clk);
        bit_stb = 1'b0;
        obs    = {tx_oe, tx_done, obs_rd, tx_dp, tx_dn};
        obs_ls = {ls_oe, ls_done, obs_rd_ls, ls_dp, ls_dn};
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst0_async = 1'b0;
        rst0_sync  = 1'b1;
        bit_stb    = 1'b0;
        tx_start   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_oe, tx_done, fifo_rd_en, tx_dp, tx_dn, tx_active} !== 6'b000100)
            $display("[TB] FAIL reset_fs: got %b, expected %b", {tx_oe, tx_done, fifo_rd_en, tx_dp, tx_dn, tx_active}, 6'b000100);
        else passes++;
        checks++;
        if ({ls_oe, ls_done, ls_dp, ls_dn, ls_active} !== 5'b00010)
            $display("[TB] FAIL reset_ls: got %b, expected %b", {ls_oe, ls_done, ls_dp, ls_dn, ls_active}, 5'b00010);
        else passes++;
        rst0_async = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_oe, tx_active, tx_dp, tx_dn} !== 4'b0010)
            $display("[TB] FAIL reset_release: got %b, expected %b", {tx_oe, tx_active, tx_dp, tx_dn}, 4'b0010);
        else passes++;
    endtask

    task automatic test_basic();
        int d0, p0;
        logic [4:0] e;
        set_pkt(16'h002D, 8);
        load_fifo();
        model_packet(1'b0);
        d0 = done_cnt;
        p0 = pop_cnt;
        start_packet(1'b1);
        checks++;
        if ({tx_active, tx_oe, tx_dp, tx_dn} !== 4'b1010)
            $display("[TB] FAIL accept_no_bit: got %b, expected %b", {tx_active, tx_oe, tx_dp, tx_dn}, 4'b1010);
        else passes++;
        while (exp_q.size() > 0) begin
            step_bit();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("[TB] FAIL basic_symbol: got %b, expected %b", obs, e);
            else passes++;
        end
        checks++;
        if (done_cnt - d0 !== 1) $display("[TB] FAIL basic_done_count: got %0d, expected 1", done_cnt - d0);
        else passes++;
        checks++;
        if (pop_cnt - p0 !== 8) $display("[TB] FAIL basic_pops: got %0d, expected 8", pop_cnt - p0);
        else passes++;
        checks++;
        if (tx_active !== 1'b0) $display("[TB] FAIL basic_active_end: got %b, expected 0", tx_active);
        else passes++;
    endtask

    task automatic test_stuffing();
        int p0;
        logic [4:0] e;
        set_pkt(16'h00FF, 8);
        load_fifo();
        model_packet(1'b0);
        p0 = pop_cnt;
        start_packet(1'b0);
        while (exp_q.size() > 0) begin
            step_bit();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("[TB] FAIL stuff_symbol: got %b, expected %b", obs, e);
            else passes++;
        end
        checks++;
        if (pop_cnt - p0 !== 8) $display("[TB] FAIL stuff_pops: got %0d, expected 8", pop_cnt - p0);
        else passes++;
    endtask

    task automatic test_stuff_before_eop();
        logic [4:0] e;
        set_pkt(16'h003F, 6);
        load_fifo();
        model_packet(1'b0);
        start_packet(1'b0);
        while (exp_q.size() > 0) begin
            step_bit();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("[TB] FAIL six_ones_symbol: got %b, expected %b", obs, e);
            else passes++;
        end
        set_pkt(16'h007E, 7);
        load_fifo();
        model_packet(1'b0);
        start_packet(1'b0);
        while (exp_q.size() > 0) begin
            step_bit();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("[TB] FAIL pending_stuff_symbol: got %b, expected %b", obs, e);
            else passes++;
        end
    endtask

    task automatic test_ignored_start();
        int d0, n;
        logic [4:0] e;
        start_packet(1'b0);
        step_bit();
        step_bit();
        checks++;
        if ({tx_active, obs} !== 6'b000010)
            $display("[TB] FAIL start_when_empty: got %b, expected %b", {tx_active, obs}, 6'b000010);
        else passes++;
        set_pkt(16'h00A5, 8);
        load_fifo();
        model_packet(1'b0);
        d0 = done_cnt;
        n = 0;
        start_packet(1'b0);
        while (exp_q.size() > 0) begin
            if (n == 11) start_packet(1'b0);
            step_bit();
            n++;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) $display("[TB] FAIL start_in_data_symbol: got %b, expected %b", obs, e);
            else passes++;
        end
        step_bit();
        checks++;
        if (done_cnt - d0 !== 1 || tx_active !== 1'b0)
            $display("[TB] FAIL start_in_data_done: got %0d/%b, expected 1/0", done_cnt - d0, tx_active);
        else passes++;
    endtask

    task automatic test_sync_clear();
        int d0;
        set_pkt(16'h005A, 8);
        load_fifo();
        start_packet(1'b0);
        repeat (11) step_bit();
        checks++;
        if (obs[4] !== 1'b1) $display("[TB] FAIL sync_clear_precond: got %b, expected 1", obs[4]);
        else passes++;
        d0 = done_cnt;
        @(negedge clk);
        rst0_sync = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_oe, tx_active, tx_done, tx_dp, tx_dn} !== 5'b00010)
            $display("[TB] FAIL sync_clear_state: got %b, expected %b", {tx_oe, tx_active, tx_done, tx_dp, tx_dn}, 5'b00010);
        else passes++;
        rst0_sync = 1'b1;
        wr_ptr = rd_ptr;
        repeat (4) step_bit();
        checks++;
        if (done_cnt !== d0 || obs !== 5'b00010)
            $display("[TB] FAIL sync_clear_after: got %0d/%b, expected %0d/%b", done_cnt, obs, d0, 5'b00010);
        else passes++;
    endtask

    task automatic test_async_reset();
        int d0;
        set_pkt(16'h0033, 8);
        load_fifo();
        start_packet(1'b0);
        repeat (3) step_bit();
        d0 = done_cnt;
        @(negedge clk);
        #2;
        rst0_async = 1'b0;
        #1;
        checks++;
        if ({tx_oe, tx_active, tx_done, tx_dp, tx_dn, ls_dp, ls_dn} !== 7'b0001001)
            $display("[TB] FAIL async_reset_state: got %b, expected %b", {tx_oe, tx_active, tx_done, tx_dp, tx_dn, ls_dp, ls_dn}, 7'b0001001);
        else passes++;
        @(negedge clk);
        rst0_async = 1'b1;
        wr_ptr = rd_ptr;
        repeat (4) step_bit();
        checks++;
        if (done_cnt !== d0 || obs !== 5'b00010)
            $display("[TB] FAIL async_reset_after: got %0d/%b, expected %0d/%b", done_cnt, obs, d0, 5'b00010);
        else passes++;
    endtask

    task automatic test_low_speed();
        logic [4:0] e, e_ls;
        set_pkt(16'h00C3, 8);
        load_fifo();
        model_packet(1'b0);
        model_packet(1'b1);
        start_packet(1'b0);
        while (exp_ls_q.size() > 0) begin
            step_bit();
            e_ls = exp_ls_q.pop_front();
            checks++;
            if (obs_ls !== e_ls) $display("[TB] FAIL ls_symbol: got %b, expected %b", obs_ls, e_ls);
            else passes++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) $display("[TB] FAIL ls_fs_symbol: got %b, expected %b", obs, e);
                else passes++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) fifo_mem[i] = 1'b0;
        test_reset();
        test_basic();
        test_stuffing();
        test_stuff_before_eop();
        test_ignored_start();
        test_sync_clear();
        test_async_reset();
        test_low_speed();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
